// File: rtl/spell_mem_arb.sv
// Two-port (CPU / debug) request arbiter in front of spell_mem, with access watchdog.
// Define SPELL_MEM_ARB_RR_EN for round-robin arbitration; default is fixed debug priority.
module spell_mem_arb #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_req,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  input  logic       cpu_type_data,
  input  logic       cpu_write,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,
  input  logic       dbg_req,
  input  logic [7:0] dbg_addr,
  input  logic [7:0] dbg_wdata,
  input  logic       dbg_type_data,
  input  logic       dbg_write,
  output logic       dbg_ack,
  output logic [7:0] dbg_rdata,
  output logic       mem_select,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data_in,
  output logic       mem_type_data,
  output logic       mem_write,
  input  logic [7:0] mem_data_out,
  input  logic       mem_data_ready,
  output logic       timeout
);

  // state  | meaning
  // IDLE   | waiting for a request, mem_select low
  // ACCESS | spell_mem access in flight, mem_* held, watchdog counting
  // RESP   | one-cycle ack (and timeout flag) to the winner
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
  localparam bit         WDOG_EN  = (TIMEOUT_CYCLES != 0);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       win_dbg_q, win_dbg_d;
  logic       sel_q, sel_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       type_q, type_d;
  logic       write_q, write_d;
  logic [7:0] cpu_rdata_q, cpu_rdata_d;
  logic [7:0] dbg_rdata_q, dbg_rdata_d;
  logic       cpu_ack_q, cpu_ack_d;
  logic       dbg_ack_q, dbg_ack_d;
  logic       timeout_q, timeout_d;
  logic       grant_dbg;

`ifdef SPELL_MEM_ARB_RR_EN
  // Remembers who won the last grant; reset value means "CPU went last".
  logic last_dbg_q, last_dbg_d;

  always_comb begin
    grant_dbg  = dbg_req && (!cpu_req || !last_dbg_q);
    last_dbg_d = last_dbg_q;
    if (state_q == IDLE && (cpu_req || dbg_req)) begin
      last_dbg_d = grant_dbg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dbg_q <= 1'b0;
    end else begin
      last_dbg_q <= last_dbg_d;
    end
  end
`else
  always_comb grant_dbg = dbg_req;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_dbg_d   = win_dbg_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    type_d      = type_q;
    write_d     = write_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    cpu_ack_d   = 1'b0;
    dbg_ack_d   = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          win_dbg_d = grant_dbg;
          sel_d     = 1'b1;
          cnt_d     = 8'd0;
          addr_d    = grant_dbg ? dbg_addr      : cpu_addr;
          wdata_d   = grant_dbg ? dbg_wdata     : cpu_wdata;
          type_d    = grant_dbg ? dbg_type_data : cpu_type_data;
          write_d   = grant_dbg ? dbg_write     : cpu_write;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        // Ready takes precedence over a watchdog expiry on the same edge.
        if (mem_data_ready || (WDOG_EN && cnt_q == TO_LIMIT)) begin
          sel_d     = 1'b0;
          state_d   = RESP;
          timeout_d = !mem_data_ready;
          if (win_dbg_q) begin
            dbg_ack_d = 1'b1;
          end else begin
            cpu_ack_d = 1'b1;
          end
          if (!write_q) begin
            if (win_dbg_q) begin
              dbg_rdata_d = mem_data_ready ? mem_data_out : 8'hFF;
            end else begin
              cpu_rdata_d = mem_data_ready ? mem_data_out : 8'hFF;
            end
          end
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        sel_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      win_dbg_q   <= 1'b0;
      sel_q       <= 1'b0;
      addr_q      <= 8'd0;
      wdata_q     <= 8'd0;
      type_q      <= 1'b0;
      write_q     <= 1'b0;
      cpu_rdata_q <= 8'd0;
      dbg_rdata_q <= 8'd0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_dbg_q   <= win_dbg_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      type_q      <= type_d;
      write_q     <= write_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      timeout_q   <= timeout_d;
    end
  end

  assign mem_select    = sel_q;
  assign mem_addr      = addr_q;
  assign mem_data_in   = wdata_q;
  assign mem_type_data = type_q;
  assign mem_write     = write_q;
  assign cpu_rdata     = cpu_rdata_q;
  assign dbg_rdata     = dbg_rdata_q;
  assign cpu_ack       = cpu_ack_q;
  assign dbg_ack       = dbg_ack_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_spell_mem_arb.sv
// Bench for spell_mem_arb: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed latencies and data.
module tb_spell_mem_arb;
  localparam int TO = 4;
`ifdef SPELL_MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cpu_req = 1'b0, cpu_type_data = 1'b0, cpu_write = 1'b0;
  logic [7:0] cpu_addr = 8'd0, cpu_wdata = 8'd0;
  logic       dbg_req = 1'b0, dbg_type_data = 1'b0, dbg_write = 1'b0;
  logic [7:0] dbg_addr = 8'd0, dbg_wdata = 8'd0;
  logic [7:0] mem_data_out = 8'd0;
  logic       mem_data_ready = 1'b0;
  logic       cpu_ack, dbg_ack, mem_select, mem_type_data, mem_write, timeout;
  logic [7:0] cpu_rdata, dbg_rdata, mem_addr, mem_data_in;

  int n_checks = 0;
  int n_pass = 0;

  spell_mem_arb #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_type_data(cpu_type_data), .cpu_write(cpu_write),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_type_data(dbg_type_data), .dbg_write(dbg_write),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_select(mem_select), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_type_data(mem_type_data), .mem_write(mem_write),
    .mem_data_out(mem_data_out), .mem_data_ready(mem_data_ready),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: tracks a single outstanding transaction by its age.
  bit         m_busy = 0, m_done = 0, m_dbg = 0, m_last_dbg = 0;
  int         m_age = 0;
  logic       e_sel = 0, e_type = 0, e_wr = 0, e_cack = 0, e_dack = 0, e_to = 0;
  logic [7:0] e_addr = 0, e_wd = 0, e_crd = 0, e_drd = 0;

  task automatic model_complete(input bit aborted);
    logic [7:0] rd;
    rd = aborted ? 8'hFF : mem_data_out;
    m_busy = 0;
    m_done = 1;
    e_sel  = 0;
    e_to   = aborted;
    if (m_dbg) e_dack = 1; else e_cack = 1;
    if (!e_wr) begin
      if (m_dbg) e_drd = rd; else e_crd = rd;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_dbg = 0; m_last_dbg = 0; m_age = 0;
      e_sel = 0; e_type = 0; e_wr = 0; e_cack = 0; e_dack = 0; e_to = 0;
      e_addr = 0; e_wd = 0; e_crd = 0; e_drd = 0;
    end else if (m_done) begin
      m_done = 0; e_cack = 0; e_dack = 0; e_to = 0;
    end else if (m_busy) begin
      if (mem_data_ready) model_complete(1'b0);
      else if (TO != 0 && m_age == TO) model_complete(1'b1);
      else if (m_age < 255) m_age = m_age + 1;
    end else if (cpu_req || dbg_req) begin
      if (cpu_req && dbg_req) m_dbg = RR ? !m_last_dbg : 1'b1;
      else m_dbg = dbg_req;
      m_last_dbg = m_dbg;
      m_busy = 1;
      m_age  = 0;
      e_sel  = 1;
      e_addr = m_dbg ? dbg_addr : cpu_addr;
      e_wd   = m_dbg ? dbg_wdata : cpu_wdata;
      e_type = m_dbg ? dbg_type_data : cpu_type_data;
      e_wr   = m_dbg ? dbg_write : cpu_write;
    end
  end

  always @(negedge clk) begin
    n_checks++;
    if ({mem_select, mem_addr, mem_data_in, mem_type_data, mem_write, cpu_ack, dbg_ack,
         cpu_rdata, dbg_rdata, timeout} ===
        {e_sel, e_addr, e_wd, e_type, e_wr, e_cack, e_dack, e_crd, e_drd, e_to})
      n_pass++;
    else
      $display("FAIL cycle_model t=%0t: got sel=%b addr=%h din=%h type=%b wr=%b cack=%b dack=%b crd=%h drd=%h to=%b expected sel=%b addr=%h din=%h type=%b wr=%b cack=%b dack=%b crd=%h drd=%h to=%b",
               $time, mem_select, mem_addr, mem_data_in, mem_type_data, mem_write, cpu_ack, dbg_ack,
               cpu_rdata, dbg_rdata, timeout, e_sel, e_addr, e_wd, e_type, e_wr, e_cack, e_dack,
               e_crd, e_drd, e_to);
  end

  // One transaction from one port; waits<0 means memory never signals ready.
  task automatic run_txn(input bit use_dbg, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic typ, input logic wr, input int waits,
                         input logic [7:0] mdata, output int lat, output int sel_cyc,
                         output logic to_at_ack, output logic other_ack);
    bit done;
    @(negedge clk);
    if (use_dbg) begin
      dbg_req = 1; dbg_addr = addr; dbg_wdata = wdata; dbg_type_data = typ; dbg_write = wr;
    end else begin
      cpu_req = 1; cpu_addr = addr; cpu_wdata = wdata; cpu_type_data = typ; cpu_write = wr;
    end
    lat = 0; sel_cyc = 0; to_at_ack = 0; other_ack = 0; done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (use_dbg ? dbg_ack : cpu_ack) begin
        done = 1;
        to_at_ack = timeout;
      end else begin
        if (use_dbg ? cpu_ack : dbg_ack) other_ack = 1;
        if (mem_select) begin
          if (sel_cyc == waits) begin
            mem_data_ready = 1;
            mem_data_out = mdata;
          end
          sel_cyc++;
        end
      end
    end
    mem_data_ready = 0;
    cpu_req = 0;
    dbg_req = 0;
    check("txn_ack_seen", {31'd0, done}, 32'd1);
  endtask

  int lat, selc, nack;
  logic to_a, oth;
  logic [3:0] order, exp_order;

  initial begin
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {26'd0, mem_select, mem_type_data, mem_write, cpu_ack, dbg_ack, timeout}, 32'd0);
    check("reset_data", {mem_addr, mem_data_in, cpu_rdata, dbg_rdata}, 32'd0);
    rst_n = 1;

    // CPU read, zero wait
    run_txn(0, 8'h10, 8'h00, 1, 0, 0, 8'hA5, lat, selc, to_a, oth);
    check("t1_latency", lat, 2);
    check("t1_select_cycles", selc, 1);
    check("t1_cpu_rdata", cpu_rdata, 8'hA5);
    check("t1_no_dbg_ack", {31'd0, oth}, 32'd0);

    // Debug write, 3 wait states
    run_txn(1, 8'h25, 8'h3C, 0, 1, 3, 8'hEE, lat, selc, to_a, oth);
    check("t2_latency", lat, 5);
    check("t2_select_cycles", selc, 4);
    check("t2_dbg_rdata_unchanged", dbg_rdata, 8'h00);
    check("t2_mem_hold", {mem_addr, mem_data_in, 6'd0, mem_type_data, mem_write}, {8'h25, 8'h3C, 8'h01});
    check("t2_cpu_rdata_kept", cpu_rdata, 8'hA5);

    // Watchdog abort on CPU read
    run_txn(0, 8'h33, 8'h00, 1, 0, -1, 8'h00, lat, selc, to_a, oth);
    check("t3_latency", lat, 6);
    check("t3_select_cycles", selc, 5);
    check("t3_timeout_flag", {31'd0, to_a}, 32'd1);
    check("t3_cpu_rdata_ff", cpu_rdata, 8'hFF);

    // Ready arriving on the expiry edge wins
    run_txn(0, 8'h44, 8'h00, 0, 0, TO, 8'h5A, lat, selc, to_a, oth);
    check("t4_latency", lat, 6);
    check("t4_no_timeout", {31'd0, to_a}, 32'd0);
    check("t4_cpu_rdata", cpu_rdata, 8'h5A);

    // Debug read, 1 wait
    run_txn(1, 8'h58, 8'h00, 1, 0, 1, 8'hC3, lat, selc, to_a, oth);
    check("t5_latency", lat, 3);
    check("t5_dbg_rdata", dbg_rdata, 8'hC3);
    check("t5_cpu_rdata_kept", cpu_rdata, 8'h5A);

    // Reset in the middle of an access
    @(negedge clk);
    cpu_req = 1; cpu_addr = 8'h77; cpu_write = 0;
    @(negedge clk);
    check("t6_select_before_reset", {31'd0, mem_select}, 32'd1);
    #2 rst_n = 0;
    #1;
    check("t6_async_outputs", {26'd0, mem_select, mem_type_data, mem_write, cpu_ack, dbg_ack, timeout}, 32'd0);
    check("t6_async_data", {mem_addr, mem_data_in, cpu_rdata, dbg_rdata}, 32'd0);
    cpu_req = 0;
    repeat (2) @(negedge clk);
    check("t6_no_ack", {30'd0, cpu_ack, dbg_ack}, 32'd0);
    rst_n = 1;

    // Both ports held high for four back-to-back grants
    @(negedge clk);
    cpu_req = 1; cpu_addr = 8'h81; cpu_write = 0; cpu_type_data = 1;
    dbg_req = 1; dbg_addr = 8'h92; dbg_write = 0; dbg_type_data = 0;
    nack = 0;
    order = 4'd0;
    for (int i = 0; i < 60 && nack < 4; i++) begin
      @(negedge clk);
      if (cpu_ack || dbg_ack) begin
        order[nack] = dbg_ack;
        nack++;
        mem_data_ready = 0;
        if (nack == 4) begin
          cpu_req = 0;
          dbg_req = 0;
        end
      end else if (mem_select && !mem_data_ready) begin
        mem_data_ready = 1;
        mem_data_out = 8'h60 + 8'(nack);
      end
    end
    mem_data_ready = 0; cpu_req = 0; dbg_req = 0;
    exp_order = RR ? 4'b0101 : 4'b1111;
    check("t7_grant_count", nack, 4);
    for (int i = 0; i < 4; i++) check($sformatf("t7_grant_%0d_is_dbg", i), {31'd0, order[i]}, {31'd0, exp_order[i]});
    check("t7_dbg_rdata_last", dbg_rdata, RR ? 8'h62 : 8'h63);

    // Lone CPU read after the contention run
    run_txn(0, 8'hE0, 8'h00, 1, 0, 0, 8'h3E, lat, selc, to_a, oth);
    check("t8_latency", lat, 2);
    check("t8_cpu_rdata", cpu_rdata, 8'h3E);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no finish expected finish before 200000");
    $fatal(1, "time limit");
  end

endmodule
